// File: rtl/pool_window_sequencer.sv
// Row-buffered 2x2 window sequencer: gathers non-overlapping windows from a raster
// pixel stream, hands each to the pooling stage and forwards the pooled result.
module pool_window_sequencer #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] win00,
  output logic [DATA_W-1:0] win01,
  output logic [DATA_W-1:0] win10,
  output logic [DATA_W-1:0] win11,
  output logic              start,
  input  logic              finish,
  input  logic [DATA_W-1:0] pool_in,
  output logic [DATA_W-1:0] pool_out,
  output logic              pool_valid,
  input  logic              pool_ready,
  output logic              frame_done
);

  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic [DATA_W-1:0] linebuf_r [IMG_W];
  logic [DATA_W-1:0] prev_pix_r;
  logic [DATA_W-1:0] win00_r, win01_r, win10_r, win11_r;
  logic [DATA_W-1:0] pool_out_r;
  logic              pix_ready_r, start_r, pool_valid_r, last_win_r;
  logic              pix_ready_s, start_s, pool_valid_s, capture_s;
  logic              accept_s, win_done_s;

  assign accept_s   = pix_valid & pix_ready_r;
  assign win_done_s = accept_s & row_r[0] & col_r[0];

  // Next-state and next-output decode for the window handshake FSM
  always_comb begin
    state_s      = state_r;
    pix_ready_s  = 1'b0;
    start_s      = 1'b0;
    pool_valid_s = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_ACCEPT: begin
        if (win_done_s) begin
          state_s = ST_ISSUE;
          start_s = 1'b1;
        end else begin
          pix_ready_s = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (finish) begin
          state_s      = ST_OUTPUT;
          pool_valid_s = 1'b1;
          capture_s    = 1'b1;
        end else begin
          start_s = 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (pool_ready) begin
          state_s     = ST_ACCEPT;
          pix_ready_s = 1'b1;
        end else begin
          pool_valid_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_ACCEPT;
      end
    endcase
  end

  // FSM state, handshake outputs and captured pooled result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_ACCEPT;
      pix_ready_r  <= 1'b0;
      start_r      <= 1'b0;
      pool_valid_r <= 1'b0;
      pool_out_r   <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_s;
      pix_ready_r  <= pix_ready_s;
      start_r      <= start_s;
      pool_valid_r <= pool_valid_s;
      if (capture_s) begin
        pool_out_r <= pool_in;
      end
    end
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if (accept_s) begin
      if (col_r == COL_LAST) begin
        col_r <= {COL_W{1'b0}};
        row_r <= (row_r == ROW_LAST) ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Even-row line buffer; contents after reset are never read before being rewritten
  always_ff @(posedge clk) begin
    if (accept_s && !row_r[0]) begin
      linebuf_r[col_r] <= pix_in;
    end
  end

  // Odd-row left pixel and window registers, frozen while a window is outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pix_r <= {DATA_W{1'b0}};
      win00_r    <= {DATA_W{1'b0}};
      win01_r    <= {DATA_W{1'b0}};
      win10_r    <= {DATA_W{1'b0}};
      win11_r    <= {DATA_W{1'b0}};
      last_win_r <= 1'b0;
    end else begin
      if (accept_s && row_r[0] && !col_r[0]) begin
        prev_pix_r <= pix_in;
      end
      if (win_done_s) begin
        win00_r    <= linebuf_r[col_r - COL_W'(1)];
        win01_r    <= linebuf_r[col_r];
        win10_r    <= prev_pix_r;
        win11_r    <= pix_in;
        last_win_r <= (row_r == ROW_LAST) && (col_r == COL_LAST);
      end
    end
  end

  assign pix_ready  = pix_ready_r;
  assign start      = start_r;
  assign pool_valid = pool_valid_r;
  assign pool_out   = pool_out_r;
  assign win00      = win00_r;
  assign win01      = win01_r;
  assign win10      = win10_r;
  assign win11      = win11_r;
  // Pulses during the handshake cycle of the frame's final pooled pixel
  assign frame_done = pool_valid_r & pool_ready & last_win_r;

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Scoreboard bench for pool_window_sequencer on a 4x4 map with a sum>>2 pooling model.
module tb_pool_window_sequencer;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] win00, win01, win10, win11;
  logic          start, finish;
  logic [DW-1:0] pool_in, pool_out;
  logic          pool_valid;
  logic          pool_ready = 1'b1;
  logic          frame_done;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q[$];
  bit            last_q[$];
  int exp_pushed = 0;
  int start_rises = 0;
  int fin_delay = 0;
  int fin_cnt = 0;
  int exp_start_len = 1;
  int start_len = 0;
  logic [4*DW-1:0] win_hold;
  logic [17:0] pool_sum;

  pool_window_sequencer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win00(win00), .win01(win01), .win10(win10), .win11(win11),
    .start(start), .finish(finish), .pool_in(pool_in),
    .pool_out(pool_out), .pool_valid(pool_valid), .pool_ready(pool_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Pooling stage model: average of the window, finish after fin_delay extra cycles
  assign pool_sum = 18'(win00) + 18'(win01) + 18'(win10) + 18'(win11);
  assign pool_in  = pool_sum[17:2];
  assign finish   = start && (fin_cnt >= fin_delay);
  always @(posedge clk) begin
    if (start && !finish) fin_cnt <= fin_cnt + 1;
    else fin_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] v, input bit last);
    exp_q.push_back(v);
    last_q.push_back(last);
    exp_pushed++;
  endtask

  task automatic push_frame_ramp();
    push_exp(16'd2, 1'b0);
    push_exp(16'd4, 1'b0);
    push_exp(16'd10, 1'b0);
    push_exp(16'd12, 1'b1);
  endtask

  // Called at a falling edge; returns at the falling edge after the pixel is taken
  task automatic send_pix(input logic [DW-1:0] v);
    int n = 0;
    pix_in = v;
    pix_valid = 1'b1;
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) chk("pix_ready_timeout", 32'(pix_ready), 32'd1);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_pool_valid"}, 32'(pool_valid), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_pool_out"}, 32'(pool_out), 32'd0);
    chk({tag, "_win"}, 32'(win00 | win01 | win10 | win11), 32'd0);
  endtask

  // Output monitor: pops the scoreboard on every accepted pooled pixel
  always @(negedge clk) begin
    if (rst_n && pool_valid && pool_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", pool_out);
      end else begin
        chk("pool_out", 32'(pool_out), 32'(exp_q.pop_front()));
        chk("frame_done", 32'(frame_done), 32'(last_q.pop_front()));
      end
    end else if (frame_done) begin
      chk("frame_done_spurious", 32'(frame_done), 32'd0);
    end
  end

  // Start-episode monitor: length, window stability and episode count
  always @(negedge clk) begin
    if (start) begin
      if (start_len > 0 && {win00, win01, win10, win11} !== win_hold)
        chk("win_stable", 32'(win00), 32'(win_hold[4*DW-1:3*DW]));
      if (start_len == 0) start_rises++;
      win_hold = {win00, win01, win10, win11};
      start_len++;
    end else if (start_len > 0) begin
      chk("start_len", 32'(start_len), 32'(exp_start_len));
      start_len = 0;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset("init");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("pix_ready_rise", 32'(pix_ready), 32'd1);
    @(negedge clk);

    // Basic frame with exact handshake timing around the 6th accept
    push_frame_ramp();
    for (int i = 0; i < 5; i++) send_pix(DW'(i));
    pix_in = 16'd5;
    pix_valid = 1'b1;
    chk("t0_pix_ready", 32'(pix_ready), 32'd1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk("t1_start", 32'(start), 32'd1);
    chk("t1_pix_ready", 32'(pix_ready), 32'd0);
    chk("t1_pool_valid", 32'(pool_valid), 32'd0);
    @(posedge clk); #1;
    chk("t2_start", 32'(start), 32'd0);
    chk("t2_pool_valid", 32'(pool_valid), 32'd1);
    chk("t2_pix_ready", 32'(pix_ready), 32'd0);
    @(posedge clk); #1;
    chk("t3_pix_ready", 32'(pix_ready), 32'd1);
    chk("t3_pool_valid", 32'(pool_valid), 32'd0);
    @(negedge clk);
    for (int i = 6; i < 16; i++) send_pix(DW'(i));
    drain("drain_basic");

    // Delayed finish: start held 4 cycles per window
    fin_delay = 3;
    exp_start_len = 4;
    push_frame_ramp();
    for (int i = 0; i < 16; i++) send_pix(DW'(i));
    drain("drain_delayed");
    fin_delay = 0;
    exp_start_len = 1;

    // Output backpressure on the first window of a flat frame
    for (int k = 0; k < 4; k++) push_exp(16'h0100, k == 3);
    fork
      begin
        for (int i = 0; i < 16; i++) send_pix(16'h0100);
      end
      begin
        int n = 0;
        @(posedge clk); #1;
        while (!pool_valid && n < 500) begin
          @(posedge clk); #1;
          n++;
        end
        pool_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(posedge clk); #1;
          chk("bp_pool_valid", 32'(pool_valid), 32'd1);
          chk("bp_pool_out", 32'(pool_out), 32'h0100);
          chk("bp_pix_ready", 32'(pix_ready), 32'd0);
        end
        pool_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Upstream gaps
    push_frame_ramp();
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_pix(DW'(i));
    end
    drain("drain_gaps");

    // Reset after 7 pixels, then a clean frame
    push_exp(16'd2, 1'b0);
    for (int i = 0; i < 7; i++) send_pix(DW'(i));
    drain("drain_partial");
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_frame_ramp();
    for (int i = 0; i < 16; i++) send_pix(DW'(i));
    drain("drain_after_reset");

    chk("start_episodes", 32'(start_rises), 32'(exp_pushed));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
